// File: rtl/musa_stack_pkg.sv
// Shared defaults and types for the MUSA return-address stack.
package musa_stack_pkg;

  localparam int STACK_WIDTH = 18;
  localparam int STACK_DEPTH = 8;
  localparam int STACK_CNT_W = $clog2(STACK_DEPTH) + 1;

  typedef logic [STACK_WIDTH-1:0] pc_t;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector: one-cycle pulse on each 0->1 transition.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Remember last cycle's level; cleared on reset so a request held
  // through reset release fires once on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/stack.sv
// Return-address LIFO for the MUSA core. Push/pop act once per request
// edge; the popped PC is presented on a registered output.
module stack
  import musa_stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         read_PC,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         write_PC,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             push_ev;
  logic             pop_ev;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] wpc_q, wpc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;
  logic [WIDTH-1:0] mem [DEPTH];

  rise_detect u_push_rise (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (push),
    .rise_o  (push_ev)
  );

  rise_detect u_pop_rise (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (pop),
    .rise_o  (pop_ev)
  );

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  // Top entry index; only used when the stack is non-empty.
  assign top_idx  = count_q[AW-1:0] - AW'(1);

  // Next-state for pointer, popped value, sticky flags and storage write.
  always_comb begin
    count_d   = count_q;
    wpc_d     = wpc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[AW-1:0];
    if (push_ev && pop_ev) begin
      if (is_empty) begin
        // Pop fails, push still lands in slot 0.
        unf_d     = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = '0;
        count_d   = CW'(1);
      end else begin
        // Swap: return the old top and replace it in place.
        wpc_d     = mem[top_idx];
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
    end else if (push_ev) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop_ev) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        wpc_d   = mem[top_idx];
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wpc_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wpc_q   <= wpc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= read_PC;
    end
  end

  assign write_PC  = wpc_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack.sv
// Directed bench for the MUSA return-address stack.
module tb_stack;
  import musa_stack_pkg::*;

  logic       clk;
  logic       rst_n;
  pc_t        read_PC;
  logic       push;
  logic       pop;
  pc_t        write_PC;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int tests;
  int fails;

  stack #(.WIDTH(18), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_PC   (read_PC),
    .push      (push),
    .pop       (pop),
    .write_PC  (write_PC),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    read_PC = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_push(input pc_t v, input int hold);
    read_PC = v;
    push    = 1'b1;
    repeat (hold) step();
    push = 1'b0;
    step();
  endtask

  task automatic do_pop(input int hold);
    pop = 1'b1;
    repeat (hold) step();
    pop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    do_push(18'h00011, 1);
    do_push(18'h00022, 1);
    do_push(18'h00033, 1);
    do_pop(1);
    tests++;
    if (write_PC !== 18'h00033) begin
      fails++; $display("FAIL reset_pre_wpc got=%h exp=%h", write_PC, 18'h00033);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++; $display("FAIL reset_async_cnt got count=%0d empty=%b full=%b exp 0/1/0", count, empty, full);
    end
    tests++;
    if (write_PC !== 18'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      fails++; $display("FAIL reset_async_out got wpc=%h ovf=%b unf=%b exp 0/0/0", write_PC, overflow, underflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    do_pop(1);
    tests++;
    if (underflow !== 1'b1 || count !== 4'd0 || write_PC !== 18'h0) begin
      fails++; $display("FAIL reset_then_pop got unf=%b count=%0d wpc=%h exp 1/0/0", underflow, count, write_PC);
    end
  endtask

  task automatic test_release_with_request();
    rst_n   = 1'b0;
    pop     = 1'b0;
    read_PC = 18'h00777;
    push    = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    tests++;
    if (count !== 4'd1) begin
      fails++; $display("FAIL release_push got count=%0d exp=1", count);
    end
    push = 1'b0;
    step();
    do_pop(1);
    tests++;
    if (write_PC !== 18'h00777) begin
      fails++; $display("FAIL release_pop got=%h exp=%h", write_PC, 18'h00777);
    end
  endtask

  task automatic test_lifo();
    pc_t vals [5];
    vals = '{18'h00001, 18'h2ABCD, 18'h3FFFF, 18'h12345, 18'h00F0F};
    apply_reset();
    for (int i = 0; i < 5; i++) do_push(vals[i], 5);
    tests++;
    if (count !== 4'd5) begin
      fails++; $display("FAIL lifo_count got=%0d exp=5", count);
    end
    for (int i = 4; i >= 0; i--) begin
      do_pop(10);
      tests++;
      if (write_PC !== vals[i]) begin
        fails++; $display("FAIL lifo_pop%0d got=%h exp=%h", 4 - i, write_PC, vals[i]);
      end
    end
    tests++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      fails++; $display("FAIL lifo_empty got empty=%b unf=%b exp 1/0", empty, underflow);
    end
  endtask

  task automatic test_held();
    apply_reset();
    do_push(18'h00001, 20);
    tests++;
    if (count !== 4'd1) begin
      fails++; $display("FAIL held_push got count=%0d exp=1", count);
    end
    do_pop(20);
    tests++;
    if (write_PC !== 18'h00001 || count !== 4'd0 || underflow !== 1'b0) begin
      fails++; $display("FAIL held_pop got wpc=%h count=%0d unf=%b exp 00001/0/0", write_PC, count, underflow);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 1; i <= 8; i++) do_push(pc_t'(i), 1);
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
      fails++; $display("FAIL full_set got full=%b count=%0d ovf=%b exp 1/8/0", full, count, overflow);
    end
    do_push(18'h00009, 1);
    tests++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      fails++; $display("FAIL full_ovf got ovf=%b count=%0d exp 1/8", overflow, count);
    end
    for (int i = 8; i >= 1; i--) begin
      do_pop(1);
      tests++;
      if (write_PC !== pc_t'(i)) begin
        fails++; $display("FAIL full_pop%0d got=%h exp=%h", 8 - i, write_PC, pc_t'(i));
      end
    end
    tests++;
    if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b1) begin
      fails++; $display("FAIL full_drain got empty=%b full=%b ovf=%b exp 1/0/1", empty, full, overflow);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    do_push(18'h00005, 1);
    do_pop(1);
    tests++;
    if (write_PC !== 18'h00005 || underflow !== 1'b0) begin
      fails++; $display("FAIL unf_setup got wpc=%h unf=%b exp 00005/0", write_PC, underflow);
    end
    do_pop(1);
    tests++;
    if (write_PC !== 18'h00005 || underflow !== 1'b1 || count !== 4'd0) begin
      fails++; $display("FAIL unf_pop got wpc=%h unf=%b count=%0d exp 00005/1/0", write_PC, underflow, count);
    end
    do_push(18'h00006, 1);
    tests++;
    if (count !== 4'd1 || underflow !== 1'b1) begin
      fails++; $display("FAIL unf_sticky got count=%0d unf=%b exp 1/1", count, underflow);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    do_push(18'h0000A, 1);
    do_push(18'h0000B, 1);
    read_PC = 18'h0000C;
    push    = 1'b1;
    pop     = 1'b1;
    step();
    push = 1'b0;
    pop  = 1'b0;
    step();
    tests++;
    if (write_PC !== 18'h0000B || count !== 4'd2) begin
      fails++; $display("FAIL simul_swap got wpc=%h count=%0d exp 0000b/2", write_PC, count);
    end
    tests++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      fails++; $display("FAIL simul_flags got ovf=%b unf=%b exp 0/0", overflow, underflow);
    end
    do_pop(1);
    tests++;
    if (write_PC !== 18'h0000C) begin
      fails++; $display("FAIL simul_pop1 got=%h exp=%h", write_PC, 18'h0000C);
    end
    do_pop(1);
    tests++;
    if (write_PC !== 18'h0000A || empty !== 1'b1) begin
      fails++; $display("FAIL simul_pop2 got wpc=%h empty=%b exp 0000a/1", write_PC, empty);
    end
  endtask

  task automatic test_simultaneous_empty();
    apply_reset();
    read_PC = 18'h00007;
    push    = 1'b1;
    pop     = 1'b1;
    step();
    push = 1'b0;
    pop  = 1'b0;
    step();
    tests++;
    if (underflow !== 1'b1 || count !== 4'd1 || write_PC !== 18'h0) begin
      fails++; $display("FAIL simul_empty got unf=%b count=%0d wpc=%h exp 1/1/0", underflow, count, write_PC);
    end
    do_pop(1);
    tests++;
    if (write_PC !== 18'h00007 || empty !== 1'b1) begin
      fails++; $display("FAIL simul_empty_pop got wpc=%h empty=%b exp 00007/1", write_PC, empty);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    read_PC = '0;
    test_reset();
    test_release_with_request();
    test_lifo();
    test_held();
    test_full();
    test_underflow();
    test_simultaneous();
    test_simultaneous_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
